// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: line/frame phase encoding and default
// 640x480 timing constants for the horizontal and vertical counters.
package vga_timing_pkg;

   localparam int COUNT_W = 10;

   // Phase encoding is shared with the vertical counter; keep values fixed.
   typedef enum logic [1:0] {
      FRONT_PORCH = 2'd0,
      PULSE       = 2'd1,
      BACK_PORCH  = 2'd2,
      DISPLAY     = 2'd3
   } phase_t;

   localparam int H_CLKS        = 800;
   localparam int H_DISPLAY     = 640;
   localparam int H_PULSE       = 96;
   localparam int H_FRONT_PORCH = 16;
   localparam int H_BACK_PORCH  = 48;

   localparam int V_CLKS        = 525;
   localparam int V_DISPLAY     = 480;
   localparam int V_PULSE       = 2;
   localparam int V_FRONT_PORCH = 10;
   localparam int V_BACK_PORCH  = 33;

   function automatic bit timing_ok(input int clks, input int display,
                                    input int pulse, input int front_porch,
                                    input int back_porch);
      return clks == (display + pulse + front_porch + back_porch);
   endfunction

endpackage

// File: rtl/horizontal_counter_if.sv
// Pixel-tick input and line-timing outputs of the horizontal counter.
interface horizontal_counter_if;
   import vga_timing_pkg::*;

   logic               i_pix_en;
   logic               o_Hsync;
   logic               o_h_display;
   logic [COUNT_W-1:0] o_h_pixel;
   logic               o_line_end;

   modport master (
      input  i_pix_en,
      output o_Hsync,
      output o_h_display,
      output o_h_pixel,
      output o_line_end
   );

   modport slave (
      output i_pix_en,
      input  o_Hsync,
      input  o_h_display,
      input  o_h_pixel,
      input  o_line_end
   );

endinterface

// File: rtl/horizontal_counter.sv
// Horizontal VGA timing generator: walks front porch, sync, back porch and
// display per line, advancing one position per enabled pixel tick.
//
// state       | meaning
// FRONT_PORCH | count in [0, FP), hsync idle high
// PULSE       | count in [FP, SP), hsync driven low
// BACK_PORCH  | count in [SP, BP), hsync idle high
// DISPLAY     | count in [BP, HSYNC_CLKS), pixel column valid
module horizontal_counter
   import vga_timing_pkg::*;
#(
   parameter int HSYNC_CLKS        = H_CLKS,
   parameter int HSYNC_DISPLAY     = H_DISPLAY,
   parameter int HSYNC_PULSE       = H_PULSE,
   parameter int HSYNC_FRONT_PORCH = H_FRONT_PORCH,
   parameter int HSYNC_BACK_PORCH  = H_BACK_PORCH
)(
   input logic                  clk,
   input logic                  reset,
   horizontal_counter_if.master hc
);

   localparam int FP = HSYNC_FRONT_PORCH;
   localparam int SP = FP + HSYNC_PULSE;
   localparam int BP = SP + HSYNC_BACK_PORCH;

   localparam logic [COUNT_W-1:0] FP_LAST   = COUNT_W'(FP - 1);
   localparam logic [COUNT_W-1:0] SP_LAST   = COUNT_W'(SP - 1);
   localparam logic [COUNT_W-1:0] BP_LAST   = COUNT_W'(BP - 1);
   localparam logic [COUNT_W-1:0] LINE_LAST = COUNT_W'(HSYNC_CLKS - 1);
   localparam logic [COUNT_W-1:0] BP_START  = COUNT_W'(BP);

   generate
      if (!timing_ok(HSYNC_CLKS, HSYNC_DISPLAY, HSYNC_PULSE,
                     HSYNC_FRONT_PORCH, HSYNC_BACK_PORCH)) begin : g_cfg_err
         $error("horizontal_counter: HSYNC_CLKS does not equal the sum of the phase lengths");
      end
   endgenerate

   phase_t             state, state_nxt;
   logic [COUNT_W-1:0] count, count_nxt;
   logic               wrap;
   logic               hsync_q, hsync_nxt;
   logic               display_q, display_nxt;
   logic [COUNT_W-1:0] pixel_q, pixel_nxt;
   logic               line_end_q, line_end_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FRONT_PORCH;
         count      <= '0;
         hsync_q    <= 1'b1;
         display_q  <= 1'b0;
         pixel_q    <= '0;
         line_end_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         hsync_q    <= hsync_nxt;
         display_q  <= display_nxt;
         pixel_q    <= pixel_nxt;
         line_end_q <= line_end_nxt;
      end
   end

   // Outputs are derived from the next state/count so they land in the same
   // cycle as the count they describe, with no extra pipeline stage.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      wrap         = 1'b0;
      line_end_nxt = 1'b0;
      if (hc.i_pix_en) begin
         wrap         = (count == LINE_LAST);
         count_nxt    = wrap ? '0 : count + 1'b1;
         line_end_nxt = wrap;
         case (state)
            FRONT_PORCH: if (count == FP_LAST) state_nxt = PULSE;
            PULSE:       if (count == SP_LAST) state_nxt = BACK_PORCH;
            BACK_PORCH:  if (count == BP_LAST) state_nxt = DISPLAY;
            DISPLAY:     if (wrap)             state_nxt = FRONT_PORCH;
            default:                           state_nxt = FRONT_PORCH;
         endcase
      end
      hsync_nxt   = (state_nxt != PULSE);
      display_nxt = (state_nxt == DISPLAY);
      pixel_nxt   = display_nxt ? (count_nxt - BP_START) : '0;
   end

   assign hc.o_Hsync     = hsync_q;
   assign hc.o_h_display = display_q;
   assign hc.o_h_pixel   = pixel_q;
   assign hc.o_line_end  = line_end_q;

endmodule

// File: tb/tb_horizontal_counter.sv
// Directed bench for horizontal_counter: default 800-tick line plus a
// reduced 16-tick line, both checked each cycle against a position model.
module tb_horizontal_counter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pix_en = 1'b1;

   always #5 clk = ~clk;

   horizontal_counter_if hif0 ();
   horizontal_counter_if hif1 ();
   assign hif0.i_pix_en = pix_en;
   assign hif1.i_pix_en = pix_en;

   horizontal_counter dut (
      .clk   (clk),
      .reset (reset),
      .hc    (hif0.master)
   );

   horizontal_counter #(
      .HSYNC_CLKS        (16),
      .HSYNC_DISPLAY     (8),
      .HSYNC_PULSE       (2),
      .HSYNC_FRONT_PORCH (2),
      .HSYNC_BACK_PORCH  (4)
   ) dut_s (
      .clk   (clk),
      .reset (reset),
      .hc    (hif1.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: line position per instance; phases follow from position ranges.
   int p_clks[2] = '{800, 16};
   int p_fp[2]   = '{16, 2};
   int p_sp[2]   = '{112, 4};
   int p_bp[2]   = '{160, 8};
   int m_pos[2]  = '{0, 0};
   bit m_le[2]   = '{1'b0, 1'b0};
   bit m_valid   = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_pos[k] = 0;
            m_le[k]  = 1'b0;
         end else if (pix_en) begin
            m_le[k]  = (m_pos[k] == p_clks[k] - 1);
            m_pos[k] = (m_pos[k] + 1) % p_clks[k];
         end else begin
            m_le[k] = 1'b0;
         end
      end
      if (reset) m_valid = 1'b1;
   end

   function automatic logic [31:0] e_hsync(input int k);
      return (m_pos[k] >= p_fp[k] && m_pos[k] < p_sp[k]) ? 32'd0 : 32'd1;
   endfunction
   function automatic logic [31:0] e_disp(input int k);
      return (m_pos[k] >= p_bp[k]) ? 32'd1 : 32'd0;
   endfunction
   function automatic logic [31:0] e_pix(input int k);
      return (m_pos[k] >= p_bp[k]) ? 32'(m_pos[k] - p_bp[k]) : 32'd0;
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         check("hsync",     32'(hif0.o_Hsync),     e_hsync(0));
         check("display",   32'(hif0.o_h_display), e_disp(0));
         check("pixel",     32'(hif0.o_h_pixel),   e_pix(0));
         check("line_end",  32'(hif0.o_line_end),  32'(m_le[0]));
         check("s_hsync",   32'(hif1.o_Hsync),     e_hsync(1));
         check("s_display", 32'(hif1.o_h_display), e_disp(1));
         check("s_pixel",   32'(hif1.o_h_pixel),   e_pix(1));
         check("s_line_end",32'(hif1.o_line_end),  32'(m_le[1]));
      end
   end

   // Inputs change on the falling edge; outputs of the following rising
   // edge are then sampled at the next falling edge.
   task automatic step(input logic en, input logic rst);
      pix_en = en;
      reset  = rst;
      @(negedge clk);
   endtask

   int lows, disps, les, first_low, first_disp, s_lows, s_disps, s_les;

   initial begin
      @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1);
         check("rst_hsync",    32'(hif0.o_Hsync),     32'd1);
         check("rst_display",  32'(hif0.o_h_display), 32'd0);
         check("rst_pixel",    32'(hif0.o_h_pixel),   32'd0);
         check("rst_line_end", 32'(hif0.o_line_end),  32'd0);
      end

      lows = 0; disps = 0; les = 0; first_low = -1; first_disp = -1;
      s_lows = 0; s_disps = 0; s_les = 0;
      for (int i = 1; i <= 1600; i++) begin
         step(1'b1, 1'b0);
         if (!hif0.o_Hsync) begin lows++; if (first_low < 0) first_low = i; end
         if (hif0.o_h_display) begin disps++; if (first_disp < 0) first_disp = i; end
         if (hif0.o_line_end) les++;
         if (!hif1.o_Hsync) s_lows++;
         if (hif1.o_h_display) s_disps++;
         if (hif1.o_line_end) s_les++;
         if (i == 1599) check("last_pixel", 32'(hif0.o_h_pixel), 32'd639);
      end
      check("hsync_first_low",  first_low,  16);
      check("hsync_low_cycles", lows,       192);
      check("disp_first",       first_disp, 160);
      check("disp_cycles",      disps,      1280);
      check("line_end_count",   les,        2);
      check("s_hsync_low",      s_lows,     200);
      check("s_disp_cycles",    s_disps,    800);
      check("s_line_end_count", s_les,      100);

      lows = 0; disps = 0; les = 0;
      for (int i = 0; i < 3200; i++) begin
         step((i % 4) == 0, 1'b0);
         if (!hif0.o_Hsync) lows++;
         if (hif0.o_h_display) disps++;
         if (hif0.o_line_end) les++;
      end
      check("div4_hsync_low",  lows,  384);
      check("div4_disp",       disps, 2560);
      check("div4_line_end",   les,   1);

      for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
      check("pulse_at_50", 32'(hif0.o_Hsync), 32'd0);
      step(1'b1, 1'b1);
      check("mid_rst_hsync",   32'(hif0.o_Hsync),    32'd1);
      check("mid_rst_pixel",   32'(hif0.o_h_pixel),  32'd0);
      check("mid_rst_lineend", 32'(hif0.o_line_end), 32'd0);
      lows = 0; disps = 0; les = 0; first_low = -1; first_disp = -1;
      for (int i = 1; i <= 800; i++) begin
         step(1'b1, 1'b0);
         if (!hif0.o_Hsync) begin lows++; if (first_low < 0) first_low = i; end
         if (hif0.o_h_display) begin disps++; if (first_disp < 0) first_disp = i; end
         if (hif0.o_line_end) les++;
      end
      check("post_rst_first_low",  first_low,  16);
      check("post_rst_low",        lows,       96);
      check("post_rst_first_disp", first_disp, 160);
      check("post_rst_disp",       disps,      640);
      check("post_rst_line_end",   les,        1);

      for (int i = 0; i < 799; i++) step(1'b1, 1'b0);
      check("hold_pixel_start", 32'(hif0.o_h_pixel), 32'd639);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         check("hold_pixel",    32'(hif0.o_h_pixel),   32'd639);
         check("hold_display",  32'(hif0.o_h_display), 32'd1);
         check("hold_line_end", 32'(hif0.o_line_end),  32'd0);
      end
      step(1'b1, 1'b0);
      check("wrap_line_end", 32'(hif0.o_line_end),  32'd1);
      check("wrap_pixel",    32'(hif0.o_h_pixel),   32'd0);
      check("wrap_display",  32'(hif0.o_h_display), 32'd0);
      check("wrap_hsync",    32'(hif0.o_Hsync),     32'd1);
      step(1'b0, 1'b0);
      check("wrap_pulse_width", 32'(hif0.o_line_end), 32'd0);

      for (int i = 0; i < 799; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("wrap_rst_line_end", 32'(hif0.o_line_end),  32'd0);
      check("wrap_rst_display",  32'(hif0.o_h_display), 32'd0);
      step(1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
